// File: rtl/fallthrough_small_fifo_pkg.sv
// Shared types for the fall-through FIFO: occupancy-update opcode and the
// status-flag bundle with its decode from a registered word count.
package fallthrough_small_fifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } count_op_t;

  typedef struct packed {
    logic full;
    logic nearly_full;
    logic prog_full;
    logic empty;
  } fifo_flags_t;

  function automatic fifo_flags_t decode_flags(input int unsigned count,
                                               input int unsigned depth,
                                               input int unsigned prog_thresh);
    fifo_flags_t f;
    f.full        = (count == depth);
    f.nearly_full = (count >= depth - 1);
    f.prog_full   = (count >= prog_thresh);
    f.empty       = (count == 0);
    return f;
  endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// First-word-fall-through FIFO: the head word sits on dout whenever the FIFO
// is not empty, and rd_en acknowledges (pops) it on the next rising edge.
module fallthrough_small_fifo
  import fallthrough_small_fifo_pkg::*;
#(
  parameter int WIDTH               = 72,
  parameter int MAX_DEPTH_BITS      = 3,
  parameter int PROG_FULL_THRESHOLD = 2**MAX_DEPTH_BITS - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             prog_full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;

  logic [WIDTH-1:0]        mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] rd_ptr, wr_ptr;
  logic [MAX_DEPTH_BITS:0]   count, count_next;
  logic                      wr_accept, rd_accept;
  count_op_t                 op;
  fifo_flags_t               flags;

  // A write into a full FIFO is still legal when the head is popped on the
  // same edge: it lands in the slot being vacated.
  assign wr_accept = wr_en && (!full || rd_en);
  assign rd_accept = rd_en && !empty;
  assign op        = count_op_t'({wr_accept, rd_accept});

  always_comb begin
    // NOTE: default first so every path assigns count_next; no latch inferred.
    count_next = count;
    unique case (op)
      OP_PUSH: count_next = count + 1'b1;
      OP_POP:  count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: non-blocking updates so all state registers see pre-edge values.
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // NOTE: storage is deliberately not reset; the count alone defines validity.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

  assign flags       = decode_flags(32'(count), DEPTH, PROG_FULL_THRESHOLD);
  assign full        = flags.full;
  assign nearly_full = flags.nearly_full;
  assign prog_full   = flags.prog_full;
  assign empty       = flags.empty;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset && wr_en && full && !rd_en) $display("%m: overflow, write dropped");
    if (reset && rd_en && empty)          $display("%m: underflow, read ignored");
  end
`endif

endmodule

// File: tb/tb_fallthrough_small_fifo.sv
// Self-checking bench for fallthrough_small_fifo against a queue-based model.
module tb_fallthrough_small_fifo;

  localparam int W     = 72;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         wr_en, rd_en;
  logic [W-1:0] dout;
  logic         full, nearly_full, prog_full, empty;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] model_q [$];

  fallthrough_small_fifo #(.WIDTH(W), .MAX_DEPTH_BITS(3), .PROG_FULL_THRESHOLD(7)) dut (
    .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .full(full), .nearly_full(nearly_full),
    .prog_full(prog_full), .empty(empty)
  );

  always #5 clk = ~clk;

  // {full, nearly_full, prog_full, empty} expected from model occupancy.
  function automatic logic [3:0] exp_flags();
    int n = model_q.size();
    return {n == DEPTH, n >= DEPTH - 1, n >= 7, n == 0};
  endfunction

  function automatic logic [3:0] act_flags();
    return {full, nearly_full, prog_full, empty};
  endfunction

  // One clock: apply inputs, let the edge happen, update the model, settle.
  task automatic cycle(input logic w, input logic [W-1:0] d, input logic r,
                       output logic wa, output logic ra);
    wr_en = w; din = d; rd_en = r;
    wa = w && (model_q.size() < DEPTH || r);
    ra = r && (model_q.size() > 0);
    @(posedge clk);
    if (ra) void'(model_q.pop_front());
    if (wa) model_q.push_back(d);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; din = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #12;
    model_q.delete();
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    wr_en = 0; rd_en = 0; din = '0;
    do_reset();
    checks++;
    if (act_flags() !== 4'b0001) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 0001", act_flags());
    end
  endtask

  task automatic test_single();
    logic wa, ra;
    logic [W-1:0] word = 72'h01_00000000000000AA;
    cycle(1, word, 0, wa, ra);
    checks++;
    if (empty !== 1'b0 || dout !== word) begin
      failures++;
      $display("FAIL single_fallthrough: empty=%b dout=%h expected empty=0 dout=%h", empty, dout, word);
    end
    cycle(0, '0, 1, wa, ra);
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL single_pop: empty=%b expected 1", empty);
    end
  endtask

  task automatic test_fill();
    logic wa, ra;
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, W'(i), 0, wa, ra);
      if (i == 6) begin
        checks++;
        if (act_flags() !== 4'b0110) begin
          failures++;
          $display("FAIL fill_seven_flags: got %b expected 0110", act_flags());
        end
      end
    end
    checks++;
    if (act_flags() !== 4'b1110) begin
      failures++;
      $display("FAIL fill_eight_flags: got %b expected 1110", act_flags());
    end
    cycle(1, W'(8'hFF), 0, wa, ra);
    checks++;
    if (act_flags() !== 4'b1110 || dout !== W'(0)) begin
      failures++;
      $display("FAIL overflow_drop: flags=%b dout=%h expected 1110 / 0", act_flags(), dout);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (empty !== 1'b0 || dout !== W'(i)) begin
        failures++;
        $display("FAIL fill_readback[%0d]: empty=%b dout=%h expected %h", i, empty, dout, W'(i));
      end
      cycle(0, '0, 1, wa, ra);
    end
    checks++;
    if (act_flags() !== 4'b0001) begin
      failures++;
      $display("FAIL fill_drained: flags=%b expected 0001", act_flags());
    end
  endtask

  task automatic test_full_rw();
    logic wa, ra;
    logic [W-1:0] exp;
    for (int i = 0; i < DEPTH; i++) cycle(1, W'(i), 0, wa, ra);
    cycle(1, W'(8'h55), 1, wa, ra);
    checks++;
    if (full !== 1'b1) begin
      failures++;
      $display("FAIL full_rw_full: full=%b expected 1", full);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      exp = (i == DEPTH) ? W'(8'h55) : W'(i);
      checks++;
      if (empty !== 1'b0 || dout !== exp) begin
        failures++;
        $display("FAIL full_rw_read[%0d]: empty=%b dout=%h expected %h", i, empty, dout, exp);
      end
      cycle(0, '0, 1, wa, ra);
    end
    checks++;
    if (act_flags() !== 4'b0001) begin
      failures++;
      $display("FAIL full_rw_drained: flags=%b expected 0001", act_flags());
    end
  endtask

  task automatic test_stream();
    logic wa, ra, r;
    logic [W-1:0] sent [20];
    int n_sent = 0, n_recv = 0, budget = 0;
    for (int i = 0; i < 20; i++) sent[i] = {$urandom, $urandom, $urandom};
    while (n_recv < 20 && budget < 400) begin
      r = ($urandom_range(0, 3) != 0);
      if (r && !empty) begin
        checks++;
        if (dout !== sent[n_recv]) begin
          failures++;
          $display("FAIL stream_word[%0d]: dout=%h expected %h", n_recv, dout, sent[n_recv]);
        end
      end
      cycle(n_sent < 20, (n_sent < 20) ? sent[n_sent] : '0, r, wa, ra);
      if (wa) n_sent++;
      if (ra) n_recv++;
      budget++;
    end
    checks++;
    if (n_recv != 20 || act_flags() !== exp_flags() || empty !== 1'b1) begin
      failures++;
      $display("FAIL stream_complete: received=%0d flags=%b expected 20 words and 0001", n_recv, act_flags());
    end
  endtask

  task automatic test_async_reset();
    logic wa, ra;
    for (int i = 0; i < 5; i++) cycle(1, W'(100 + i), 0, wa, ra);
    checks++;
    if (act_flags() !== exp_flags()) begin
      failures++;
      $display("FAIL pre_reset_flags: got %b expected %b", act_flags(), exp_flags());
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (act_flags() !== 4'b0001) begin
      failures++;
      $display("FAIL async_reset_flags: got %b expected 0001 before next edge", act_flags());
    end
    model_q.delete();
    @(posedge clk); #2;
    reset = 1'b1;
    @(negedge clk);
    cycle(1, W'(12'hABC), 0, wa, ra);
    checks++;
    if (empty !== 1'b0 || dout !== W'(12'hABC)) begin
      failures++;
      $display("FAIL post_reset_head: empty=%b dout=%h expected 0 / abc", empty, dout);
    end
    cycle(0, '0, 1, wa, ra);
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_stale: empty=%b expected 1", empty);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_rw();
    test_stream();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fallthrough_small_fifo.md
Name: fallthrough_small_fifo

Overview:
First-word-fall-through (FWFT) synchronous FIFO for packet-path buffering of {ctrl,data} words, e.g. 72-bit {8-bit ctrl, 64-bit data}, in front of user-datapath state machines.
- The head word is always presented on dout while the FIFO is not empty.
- rd_en acknowledges (pops) the presented word.
- nearly_full provides upstream back-pressure one word before full (drives in_rdy = !nearly_full).

Parameters:
WIDTH, 72, bit width of each stored word (din/dout).
MAX_DEPTH_BITS, 3, log2 of capacity; DEPTH = 2**MAX_DEPTH_BITS words.
PROG_FULL_THRESHOLD, 2**MAX_DEPTH_BITS - 1, occupancy at or above which prog_full asserts.

Ports:
clk  input  1  single clock; all state changes on rising edge.
reset  input  1  asynchronous, active-low reset.
din  input  WIDTH  write data.
wr_en  input  1  write strobe; pushes din on the clock edge.
rd_en  input  1  read acknowledge; pops the head word on the clock edge.
dout  output  WIDTH  head word, valid whenever empty=0.
full  output  1  occupancy == DEPTH.
nearly_full  output  1  occupancy >= DEPTH-1.
prog_full  output  1  occupancy >= PROG_FULL_THRESHOLD.
empty  output  1  occupancy == 0.

Behaviour:
- Storage: DEPTH x WIDTH register array, rd_ptr and wr_ptr of MAX_DEPTH_BITS bits, occupancy counter of MAX_DEPTH_BITS+1 bits.
- Pointers wrap modulo DEPTH naturally.
- Reset (reset=0, asynchronous): rd_ptr=0, wr_ptr=0, count=0. Hence empty=1, full=0, nearly_full=0, prog_full=0. Array contents are not reset; dout is don't-care while empty.
- Reset mid-operation discards all stored words immediately.
- Write accepted at an edge when wr_en=1 and (full=0 or rd_en=1). Writes mem[wr_ptr]=din and increments wr_ptr.
- Read accepted at an edge when rd_en=1 and empty=0. Increments rd_ptr.
- Count update: +1 on accepted write only, -1 on accepted read only, unchanged when both are accepted.
- Fall-through latency: a word written at edge k appears on dout, with empty=0, immediately after edge k. dout = mem[rd_ptr] combinationally.
- After a pop at edge k, dout shows the next word (if any) immediately after edge k.
- Flags are decoded combinationally from the registered count.
- rd_en while empty: ignored; pointers and count unchanged. A simultaneous wr_en is still accepted.
- wr_en while full without rd_en: word dropped, state unchanged. Simulation-only $display warning (excluded from synthesis) for overflow and underflow.
- Simultaneous rd_en and wr_en when full: both accepted, count stays DEPTH.
- Word order is strictly preserved across pointer wrap-around.

Decomposition:
- No shared package needed. A log2/clog2 helper may come from the existing common include used by datapath modules.
- No sub-module required; one flat module. Storage array, pointers, counter and flag decode all in one file.

Test Plan:
1. Reset low then high -> empty=1, full=0, nearly_full=0, prog_full=0.
2. Write 0x01_00000000000000AA at edge k -> after edge k: empty=0 and dout=0x01_00000000000000AA. rd_en for 1 cycle -> empty=1.
3. Write 8 words 0..7 with no reads (DEPTH=8):
   - after the 7th write: nearly_full=1, prog_full=1, full=0;
   - after the 8th write: full=1;
   - a 9th write of 0xFF is dropped;
   - reading 8 times returns 0..7 in order, then empty=1.
4. Fill to 8, then assert rd_en and wr_en(0x55) together -> full stays 1. Subsequent reads return 1..7 then 0x55.
5. Stream 20 words with continuous wr_en/rd_en (pointer wrap), random out_rdy-style rd_en gaps -> output sequence identical to input, no loss or duplication.
6. Assert reset (0) asynchronously mid-stream with 5 words stored -> flags return to reset values before the next clock edge; no stale words are read afterwards.
